// File: rtl/demux_stream_n_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer: default sizes,
// error counter width, selector width helper and the routing decision type.
package demux_stream_n_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int N_OUT_DEF = 4;
    localparam int ERR_CNT_W = 8;

    // A 2-channel demux still needs one selector bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ROUTE_UNICAST,
        ROUTE_BCAST,
        ROUTE_DROP
    } route_e;

endpackage

// File: rtl/demux_stream_n_if.sv
// Producer-side stream plus N consumer-side streams of the demultiplexer.
interface demux_stream_n_if
    import demux_stream_n_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_OUT = N_OUT_DEF
) ();
    localparam int SEL_W = sel_width(N_OUT);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_bcast;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic [ERR_CNT_W-1:0]   err_cnt;

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, err_cnt
    );

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, err_cnt
    );

endinterface

// File: rtl/demux_stream_n_slot.sv
// One-entry registered output slot: holds a beat until its consumer takes it,
// and can reload in the same cycle it drains.
module demux_stream_n_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready_in,
    output logic             valid,
    output logic [WIDTH-1:0] data_out,
    output logic             free
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        free    = ~valid_q | ready_in;
        valid_d = load | (valid_q & ~ready_in);
        data_d  = load ? data_in : data_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the data register is reset too because it is observable.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid    = valid_q;
    assign data_out = data_q;

endmodule

// File: rtl/demux_stream_n.sv
// 1-to-N stream demultiplexer: unicast by selector, all-or-nothing broadcast,
// and a saturating count of beats whose selector names no channel.
module demux_stream_n
    import demux_stream_n_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_OUT = N_OUT_DEF
) (
    input logic             clk,
    input logic             rst,
    demux_stream_n_if.slave bus
);
    localparam int SEL_W = sel_width(N_OUT);

    logic [N_OUT-1:0]       slot_free;
    logic [N_OUT-1:0]       hit_vec;
    logic [N_OUT-1:0]       load_vec;
    logic [N_OUT-1:0]       valid_vec;
    logic [N_OUT*WIDTH-1:0] data_vec;
    logic                   in_range;
    logic                   accept;
    route_e                 route;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    // With a power-of-two channel count every selector value is a real channel.
    generate
        if ((1 << SEL_W) == N_OUT) begin : g_pow2
            assign in_range = 1'b1;
        end else begin : g_npow2
            assign in_range = (bus.in_sel < SEL_W'(N_OUT));
        end
    endgenerate

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        route        = ROUTE_UNICAST;
        hit_vec      = '0;
        load_vec     = '0;
        bus.in_ready = 1'b0;
        err_cnt_d    = err_cnt_q;

        if (bus.in_bcast)   route = ROUTE_BCAST;
        else if (!in_range) route = ROUTE_DROP;

        for (int k = 0; k < N_OUT; k++) hit_vec[k] = (bus.in_sel == SEL_W'(k));

        // Readiness never looks at in_valid, only at where the beat would go.
        case (route)
            ROUTE_BCAST: bus.in_ready = &slot_free;
            ROUTE_DROP:  bus.in_ready = 1'b1;
            default:     bus.in_ready = |(hit_vec & slot_free);
        endcase

        accept = bus.in_valid & bus.in_ready;

        if (accept) begin
            case (route)
                ROUTE_BCAST:   load_vec = '1;
                ROUTE_UNICAST: load_vec = hit_vec;
                default: if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_stream_n_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load_vec[k]),
            .data_in  (bus.in_data),
            .ready_in (bus.out_ready[k]),
            .valid    (valid_vec[k]),
            .data_out (data_vec[k*WIDTH +: WIDTH]),
            .free     (slot_free[k])
        );
    end

    assign bus.out_valid = valid_vec;
    assign bus.out_data  = data_vec;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_demux_stream_n.sv
// Self-checking bench: a 4-channel and a 3-channel demux checked every cycle
// against a per-channel slot model, plus directed scenarios with literal values.
module tb_demux_stream_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_stream_n_if #(.WIDTH(8), .N_OUT(4)) if4 ();
    demux_stream_n_if #(.WIDTH(8), .N_OUT(3)) if3 ();

    demux_stream_n #(.WIDTH(8), .N_OUT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    demux_stream_n #(.WIDTH(8), .N_OUT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    typedef struct packed {
        logic [15:0]      v;
        logic [15:0][7:0] d;
        logic [7:0]       err;
    } mdl_t;

    mdl_t     m4, m3;
    bit       live = 1'b0;
    int       n_checks = 0;
    int       n_err = 0;
    int       drained4 = 0;
    int       stall4 = 0;
    logic [7:0] q1 [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready(mdl_t m, int n, logic [15:0] ordy, logic [3:0] sel, logic bc);
        logic all_free;
        all_free = 1'b1;
        for (int k = 0; k < n; k++) if (m.v[k] && !ordy[k]) all_free = 1'b0;
        if (bc) return all_free;
        if (int'(sel) >= n) return 1'b1;
        return !m.v[sel] || ordy[sel];
    endfunction

    function automatic mdl_t step(mdl_t m, int n, logic r, logic iv, logic [7:0] id,
                                  logic [3:0] sel, logic bc, logic [15:0] ordy);
        mdl_t nx;
        nx = m;
        if (r) return '0;
        for (int k = 0; k < n; k++) if (m.v[k] && ordy[k]) nx.v[k] = 1'b0;
        if (iv && exp_ready(m, n, ordy, sel, bc)) begin
            if (bc) begin
                for (int k = 0; k < n; k++) begin
                    nx.v[k] = 1'b1;
                    nx.d[k] = id;
                end
            end else if (int'(sel) < n) begin
                nx.v[sel] = 1'b1;
                nx.d[sel] = id;
            end else if (m.err != 8'hFF) begin
                nx.err = m.err + 8'd1;
            end
        end
        return nx;
    endfunction

    function automatic logic [127:0] pack_data(mdl_t m, int n);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[k*8 +: 8] = m.d[k];
        return r;
    endfunction

    // Compare outputs against the model state, then advance the model with the
    // inputs that will be sampled at the coming rising edge.
    always @(negedge clk) begin
        if (live) begin
            check("in_ready4", 128'(if4.in_ready),
                  128'(exp_ready(m4, 4, 16'(if4.out_ready), 4'(if4.in_sel), if4.in_bcast)));
            check("out_valid4", 128'(if4.out_valid), 128'(m4.v[3:0]));
            check("out_data4", 128'(if4.out_data), pack_data(m4, 4));
            check("err_cnt4", 128'(if4.err_cnt), 128'(m4.err));
            check("in_ready3", 128'(if3.in_ready),
                  128'(exp_ready(m3, 3, 16'(if3.out_ready), 4'(if3.in_sel), if3.in_bcast)));
            check("out_valid3", 128'(if3.out_valid), 128'(m3.v[2:0]));
            check("out_data3", 128'(if3.out_data), pack_data(m3, 3));
            check("err_cnt3", 128'(if3.err_cnt), 128'(m3.err));
            if (!rst) begin
                drained4 += $countones(if4.out_valid & if4.out_ready);
                if (if4.in_valid && !if4.in_ready) stall4++;
                if (if4.out_valid[1] && if4.out_ready[1]) q1.push_back(if4.out_data[15:8]);
            end
        end
        m4 = step(m4, 4, rst, if4.in_valid, if4.in_data, 4'(if4.in_sel), if4.in_bcast, 16'(if4.out_ready));
        m3 = step(m3, 3, rst, if3.in_valid, if3.in_data, 4'(if3.in_sel), if3.in_bcast, 16'(if3.out_ready));
        if (rst) live = 1'b1;
    end

    task automatic send4(input logic [7:0] d, input logic [1:0] sel, input logic bc);
        bit ok;
        ok = 1'b0;
        if4.in_valid = 1'b1;
        if4.in_data  = d;
        if4.in_sel   = sel;
        if4.in_bcast = bc;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (if4.in_ready) ok = 1'b1;
            @(posedge clk);
        end
        #1 if4.in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL send4_timeout: beat %0h not accepted within 200 cycles", d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0, s0;
        logic acc4, acc3;
        if4.in_valid = 0; if4.in_data = 0; if4.in_sel = 0; if4.in_bcast = 0; if4.out_ready = 4'hF;
        if3.in_valid = 0; if3.in_data = 0; if3.in_sel = 0; if3.in_bcast = 0; if3.out_ready = 3'h7;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_valid", 128'(if4.out_valid), 128'(0));
        check("reset_ready", 128'(if4.in_ready), 128'(1));

        // Unicast to channel 2.
        send4(8'hA1, 2'd2, 1'b0);
        check("uni_valid", 128'(if4.out_valid), 128'(4'b0100));
        check("uni_data", 128'(if4.out_data[23:16]), 128'(8'hA1));
        tick();
        check("uni_clear", 128'(if4.out_valid), 128'(0));

        // Backpressure on channel 1: second beat waits, order preserved.
        q1.delete();
        if4.out_ready = 4'b1101;
        send4(8'h11, 2'd1, 1'b0);
        fork
            send4(8'h22, 2'd1, 1'b0);
            begin
                repeat (3) @(negedge clk);
                check("bp_stall", 128'(if4.in_ready), 128'(0));
                @(posedge clk);
                #1 if4.out_ready = 4'hF;
            end
        join
        repeat (3) tick();
        check("bp_count", 128'(q1.size()), 128'(2));
        if (q1.size() == 2) begin
            check("bp_first", 128'(q1[0]), 128'(8'h11));
            check("bp_second", 128'(q1[1]), 128'(8'h22));
        end

        // Broadcast blocked by full, stalled slot 2; releasing it loads all four.
        if4.out_ready = 4'b1011;
        send4(8'h33, 2'd2, 1'b0);
        fork
            send4(8'h5C, 2'd0, 1'b1);
            begin
                repeat (3) @(negedge clk);
                check("bc_stall", 128'(if4.in_ready), 128'(0));
                check("bc_hold", 128'(if4.out_valid), 128'(4'b0100));
                @(posedge clk);
                #1 if4.out_ready = 4'b0100;
            end
        join
        check("bc_valid", 128'(if4.out_valid), 128'(4'hF));
        check("bc_data", 128'(if4.out_data), 128'(32'h5C5C5C5C));
        if4.out_ready = 4'hF;
        repeat (2) tick();

        // Out-of-range selector on the 3-channel demux: dropped and counted.
        if3.in_valid = 1'b1; if3.in_sel = 2'd3; if3.in_data = 8'hEE;
        repeat (300) tick();
        if3.in_valid = 1'b0;
        check("oor_err", 128'(if3.err_cnt), 128'(8'd255));
        check("oor_valid", 128'(if3.out_valid), 128'(0));

        // Full throughput alternating channels 0 and 1.
        d0 = drained4; s0 = stall4;
        for (int i = 0; i < 100; i++) begin
            if4.in_valid = 1'b1; if4.in_sel = 2'(i % 2); if4.in_data = 8'(i); if4.in_bcast = 1'b0;
            tick();
        end
        if4.in_valid = 1'b0;
        repeat (2) tick();
        check("tp_outputs", 128'(drained4 - d0), 128'(100));
        check("tp_stalls", 128'(stall4 - s0), 128'(0));

        // Reset with slots 0 and 3 full; the beat offered during reset is lost.
        if4.out_ready = 4'b0000;
        send4(8'h01, 2'd0, 1'b0);
        send4(8'h04, 2'd3, 1'b0);
        check("pre_rst_valid", 128'(if4.out_valid), 128'(4'b1001));
        rst = 1'b1;
        if4.in_valid = 1'b1; if4.in_sel = 2'd1; if4.in_data = 8'h99;
        tick();
        rst = 1'b0;
        if4.in_valid = 1'b0;
        check("rst_valid", 128'(if4.out_valid), 128'(0));
        check("rst_data", 128'(if4.out_data), 128'(0));
        check("rst_err3", 128'(if3.err_cnt), 128'(0));
        if4.out_ready = 4'hF;
        send4(8'h77, 2'd1, 1'b0);
        check("post_rst_valid", 128'(if4.out_valid), 128'(4'b0010));
        check("post_rst_data", 128'(if4.out_data[15:8]), 128'(8'h77));

        // Randomised traffic; valid and data are held while a beat is stalled.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc4 = if4.in_valid & if4.in_ready;
            acc3 = if3.in_valid & if3.in_ready;
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 499) == 0);
            if (!if4.in_valid || acc4) begin
                if4.in_valid = ($urandom_range(0, 3) != 0);
                if4.in_data  = 8'($urandom);
            end
            if (!if3.in_valid || acc3) begin
                if3.in_valid = ($urandom_range(0, 3) != 0);
                if3.in_data  = 8'($urandom);
            end
            if4.in_sel    = 2'($urandom);
            if4.in_bcast  = ($urandom_range(0, 7) == 0);
            if4.out_ready = 4'($urandom | $urandom);
            if3.in_sel    = 2'($urandom);
            if3.in_bcast  = ($urandom_range(0, 7) == 0);
            if3.out_ready = 3'($urandom | $urandom);
        end
        rst = 1'b0;
        if4.in_valid = 1'b0;
        if3.in_valid = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
